// File: rtl/nes_pkg.sv
// -----------------------------------------------------------------------------
// nes_pkg
//   Shared definitions for the NES pad emulator and the NES reader.
//   - Button indices follow the order on the wire: A first, Right last.
//   - nes_pad_state_t is the state type of the pad-side (4021-like) FSM.
//   - next_bit_index() advances a bit index and saturates it at NES_BITS,
//     which means "all eight buttons already shifted out".
// -----------------------------------------------------------------------------
package nes_pkg;

  localparam int NES_BITS   = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } nes_pad_state_t;

  // Index of the next bit to be presented; sticks at NES_BITS once exhausted.
  function automatic logic [3:0] next_bit_index(input logic [3:0] idx);
    if (idx >= 4'(NES_BITS)) begin
      return 4'(NES_BITS);
    end
    return idx + 4'd1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
//   Brings an asynchronous level into the clk domain through a chain of
//   STAGES flops and flags its rising edge.
//
//   Ports
//     clk      in   system clock
//     rst      in   asynchronous active-high reset (all flops cleared)
//     i_async  in   level asynchronous to clk
//     o_level  out  synchronized level (last flop of the chain)
//     o_rise   out  one-cycle strobe, high in the first cycle o_level is 1
//
//   STAGES must be at least 2 to give metastability time to resolve.
// -----------------------------------------------------------------------------
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_level_d;

  // NOTE: every flop here is written with <= so that all stages sample their
  // predecessor's old value on the same edge; with = the chain would collapse
  // into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= '0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[STAGES-2:0], i_async};
      r_level_d <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_level_d;

endmodule

// File: rtl/nes_pad_emulator.sv
// -----------------------------------------------------------------------------
// nes_pad_emulator
//   Device side of the NES controller serial protocol. Behaves like the pad's
//   4021 parallel-in/serial-out register: while the host holds latch high the
//   button snapshot is reloaded continuously; after latch falls each rising
//   edge of pulse presents the next button on data (active low on the wire).
//
//   Ports
//     clk         in   system clock
//     rst         in   asynchronous active-high reset
//     buttons_in  in   [0:7] active-high buttons: A,B,Select,Start,Up,Down,
//                      Left,Right
//     latch_in    in   host latch, asynchronous to clk
//     pulse_in    in   host clock pulse, asynchronous to clk
//     data_out    out  serial data, 0 = pressed, registered
//     frame_done  out  one-cycle strobe when Right (last bit) is presented
//     bit_index   out  index of the presented bit, 0..7; 8 = exhausted
//     host_idle   out  high while no latch edge was seen for IDLE_TIMEOUT
//                      cycles
//
//   A pin edge reaches data_out after SYNC_STAGES (synchronizer) + 1 (FSM /
//   shift register) + 1 (output register) clk cycles.
// -----------------------------------------------------------------------------
module nes_pad_emulator
  import nes_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [0:NES_BITS-1] buttons_in,
  input  logic                latch_in,
  input  logic                pulse_in,
  output logic                data_out,
  output logic                frame_done,
  output logic [3:0]          bit_index,
  output logic                host_idle
);

  localparam int CNT_W = (IDLE_TIMEOUT < 1) ? 1 : $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_TIMEOUT);

  // ---------------------------------------------------------------------------
  // Synchronizers
  // ---------------------------------------------------------------------------
  logic w_latch_level;
  logic w_latch_rise;
  logic w_pulse_rise;

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_latch (
    .clk     (clk),
    .rst     (rst),
    .i_async (latch_in),
    .o_level (w_latch_level),
    .o_rise  (w_latch_rise)
  );

  // Only edges of pulse matter; its synchronized level has no consumer.
  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_pulse (
    .clk     (clk),
    .rst     (rst),
    .i_async (pulse_in),
    .o_level (),
    .o_rise  (w_pulse_rise)
  );

  // ---------------------------------------------------------------------------
  // Shift-register FSM
  // ---------------------------------------------------------------------------
  nes_pad_state_t      r_state;
  nes_pad_state_t      w_state_next;
  logic [0:NES_BITS-1] r_sreg;
  logic [0:NES_BITS-1] w_sreg_next;
  logic [3:0]          r_bit_index;
  logic [3:0]          w_bit_index_next;
  logic                r_frame_done;
  logic                w_frame_done_next;
  logic                r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sreg       <= '1;
      r_bit_index  <= '0;
      r_frame_done <= 1'b0;
      r_data       <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_sreg       <= w_sreg_next;
      r_bit_index  <= w_bit_index_next;
      r_frame_done <= w_frame_done_next;
      r_data       <= r_sreg[BTN_A];
    end
  end

  // NOTE: every signal written here gets a default before any branch; a path
  // that skipped one would make synthesis infer a latch to hold it.
  always_comb begin
    w_state_next      = r_state;
    w_sreg_next       = r_sreg;
    w_bit_index_next  = r_bit_index;
    w_frame_done_next = 1'b0;

    if (w_latch_level) begin
      // Parallel mode dominates: reload every cycle, ignore pulse, and abort
      // any frame in progress without signalling frame_done.
      w_state_next     = LOAD;
      w_sreg_next      = ~buttons_in;
      w_bit_index_next = '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Nothing to shift until the host latches once.
        end

        LOAD: begin
          // Latch fell: hold the last loaded snapshot, A is already on sreg[0].
          w_state_next = SHIFT;
        end

        SHIFT: begin
          if (w_pulse_rise) begin
            w_sreg_next      = {r_sreg[BTN_B:BTN_RIGHT], 1'b0};
            w_bit_index_next = next_bit_index(r_bit_index);
            if (r_bit_index == 4'(BTN_RIGHT - 1)) begin
              w_frame_done_next = 1'b1;
              w_state_next      = DONE;
            end
          end
        end

        DONE: begin
          // Zeros keep shifting in, like the pad's grounded serial input.
          if (w_pulse_rise) begin
            w_sreg_next      = {r_sreg[BTN_B:BTN_RIGHT], 1'b0};
            w_bit_index_next = next_bit_index(r_bit_index);
          end
        end

        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Host idle watchdog
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_idle_cnt;
  logic [CNT_W-1:0] w_idle_cnt_inc;
  logic             r_host_idle;

  assign w_idle_cnt_inc = r_idle_cnt + CNT_W'(1);

  // host_idle starts high: after reset no host has been seen yet. It only
  // rises again once a full timeout elapses after a latch edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt  <= '0;
      r_host_idle <= 1'b1;
    end else if (w_latch_rise) begin
      r_idle_cnt  <= '0;
      r_host_idle <= 1'b0;
    end else if (r_idle_cnt != IDLE_MAX) begin
      r_idle_cnt <= w_idle_cnt_inc;
      if (w_idle_cnt_inc == IDLE_MAX) begin
        r_host_idle <= 1'b1;
      end
    end
  end

  assign data_out   = r_data;
  assign frame_done = r_frame_done;
  assign bit_index  = r_bit_index;
  assign host_idle  = r_host_idle;

endmodule

// File: tb/tb_nes_pad_emulator.sv
// -----------------------------------------------------------------------------
// tb_nes_pad_emulator
//   Drives latch/pulse/buttons like an NES host and compares the pad outputs
//   every cycle against a frame-level model (snapshot + number of shifts),
//   plus hand-computed expectations for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_nes_pad_emulator;

  localparam int SYNC    = 2;
  localparam int TIMEOUT = 100;
  localparam int HOLD    = 12;

  logic       clk;
  logic       rst;
  logic [0:7] buttons_in;
  logic       latch_in;
  logic       pulse_in;
  logic       data_out;
  logic       frame_done;
  logic [3:0] bit_index;
  logic       host_idle;

  int n_checks = 0;
  int n_errors = 0;
  int fd_count = 0;
  bit cmp_en   = 0;

  nes_pad_emulator #(
    .SYNC_STAGES  (SYNC),
    .IDLE_TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .buttons_in (buttons_in),
    .latch_in   (latch_in),
    .pulse_in   (pulse_in),
    .data_out   (data_out),
    .frame_done (frame_done),
    .bit_index  (bit_index),
    .host_idle  (host_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a frame is "snapshot of buttons + shifts consumed".
  // The synchronized view of a pin is simply the pin SYNC edges ago.
  // ---------------------------------------------------------------------------
  logic [SYNC:0] lat_hist, pul_hist;   // [k] = pin value k+1 edges ago
  logic [0:7]    m_snap;
  int            m_shifts;
  bit            m_active;
  logic          m_bit;
  logic          m_data;
  logic          m_fd;
  int            m_cnt;
  logic          m_idle;

  task automatic model_reset();
    lat_hist = '0;
    pul_hist = '0;
    m_snap   = '0;
    m_shifts = 0;
    m_active = 0;
    m_bit    = 1'b1;
    m_data   = 1'b1;
    m_fd     = 1'b0;
    m_cnt    = 0;
    m_idle   = 1'b1;
  endtask

  task automatic model_step();
    logic lat_lvl, lat_rise, pul_rise;
    lat_lvl  = lat_hist[SYNC-1];
    lat_rise = lat_hist[SYNC-1] & ~lat_hist[SYNC];
    pul_rise = pul_hist[SYNC-1] & ~pul_hist[SYNC];

    m_data = m_bit;
    m_fd   = 1'b0;
    if (lat_lvl) begin
      m_snap   = buttons_in;
      m_shifts = 0;
      m_active = 1;
    end else if (pul_rise && m_active && m_shifts < 8) begin
      m_shifts++;
      if (m_shifts == 7) m_fd = 1'b1;
    end
    m_bit = (m_shifts < 8) ? ~m_snap[m_shifts] : 1'b0;

    if (lat_rise) begin
      m_cnt  = 0;
      m_idle = 1'b0;
    end else if (m_cnt < TIMEOUT) begin
      m_cnt++;
      if (m_cnt == TIMEOUT) m_idle = 1'b1;
    end

    lat_hist = {lat_hist[SYNC-1:0], latch_in};
    pul_hist = {pul_hist[SYNC-1:0], pulse_in};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cyc_data_out",   data_out,   m_data);
        check("cyc_bit_index",  bit_index,  m_shifts);
        check("cyc_frame_done", frame_done, m_fd);
        check("cyc_host_idle",  host_idle,  m_idle);
        if (frame_done === 1'b1) fd_count++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 ns after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic latch_frame(input logic [0:7] b);
    buttons_in = b;
    latch_in   = 1'b1;
    tick(HOLD);
    latch_in   = 1'b0;
    tick(HOLD);
  endtask

  task automatic pulse_once();
    pulse_in = 1'b1;
    tick(HOLD);
    pulse_in = 1'b0;
    tick(HOLD);
  endtask

  initial begin
    logic [0:7] seq;
    logic [0:7] wire_b;
    int fd_before;
    int r;

    rst        = 1'b1;
    latch_in   = 1'b0;
    pulse_in   = 1'b0;
    buttons_in = '0;
    tick(1);
    cmp_en = 1;
    tick(2);
    rst = 1'b0;
    tick(5);

    // Reset state, no activity.
    check("rst_data_out",   data_out,   1'b1);
    check("rst_bit_index",  bit_index,  4'd0);
    check("rst_host_idle",  host_idle,  1'b1);
    check("rst_frame_done", frame_done, 1'b0);

    // Start pressed: wire sequence 1,1,1,0,1,1,1,1.
    seq       = 8'b1110_1111;
    fd_before = fd_count;
    latch_frame(8'b0001_0000);
    check("start_bit0_data", data_out, seq[0]);
    check("start_bit0_idx",  bit_index, 4'd0);
    for (int i = 1; i < 8; i++) begin
      pulse_once();
      check("start_seq_data", data_out, seq[i]);
    end
    check("start_frame_done_once", fd_count - fd_before, 1);
    check("start_final_idx", bit_index, 4'd7);

    // Two extra pulses: zeros, saturate at 8, no second frame_done.
    pulse_once();
    check("extra1_data", data_out, 1'b0);
    check("extra1_idx",  bit_index, 4'd8);
    pulse_once();
    check("extra2_data", data_out, 1'b0);
    check("extra2_idx",  bit_index, 4'd8);
    check("extra_no_fd", fd_count - fd_before, 1);

    // Abort after 3 pulses with A now pressed.
    latch_frame(8'b0001_0000);
    fd_before = fd_count;
    for (int i = 0; i < 3; i++) pulse_once();
    check("abort_mid_idx", bit_index, 4'd3);
    buttons_in = 8'b1000_0000;
    latch_in   = 1'b1;
    tick(HOLD);
    check("abort_latch_idx", bit_index, 4'd0);
    latch_in = 1'b0;
    tick(HOLD);
    check("abort_data_a", data_out, 1'b0);
    check("abort_idx",    bit_index, 4'd0);
    check("abort_no_fd",  fd_count - fd_before, 0);

    // Buttons toggling and pulses while latch is high: last value wins.
    latch_in = 1'b1;
    pulse_in = 1'b1;
    for (int i = 0; i < 6; i++) begin buttons_in = 8'($urandom); tick(1); end
    pulse_in = 1'b0;
    for (int i = 0; i < 6; i++) begin buttons_in = 8'($urandom); tick(1); end
    buttons_in = 8'b0110_1001;
    wire_b     = 8'b1001_0110;
    tick(6);
    check("toggle_latch_idx", bit_index, 4'd0);
    latch_in = 1'b0;
    tick(HOLD);
    check("toggle_bit0_data", data_out, wire_b[0]);
    check("toggle_bit0_idx",  bit_index, 4'd0);
    for (int i = 1; i < 8; i++) begin
      pulse_once();
      check("toggle_seq_data", data_out, wire_b[i]);
    end

    // Idle timeout: synced edge cleared at edge e+3, high again at e+103.
    latch_in = 1'b1;
    tick(SYNC + 1);
    check("idle_cleared", host_idle, 1'b0);
    tick(HOLD - (SYNC + 1));
    latch_in = 1'b0;
    tick(SYNC + TIMEOUT - HOLD);
    check("idle_before_timeout", host_idle, 1'b0);
    tick(1);
    check("idle_at_timeout", host_idle, 1'b1);
    latch_in = 1'b1;
    tick(SYNC + 2);
    check("idle_relatch", host_idle, 1'b0);
    tick(HOLD);
    latch_in = 1'b0;
    tick(HOLD);

    // Reset in the middle of a frame takes effect immediately.
    latch_frame(8'b1011_0010);
    for (int i = 0; i < 3; i++) pulse_once();
    pulse_in = 1'b1;
    tick(SYNC + 2);
    check("pre_rst_idx", bit_index, 4'd4);
    rst = 1'b1;
    #1;
    check("midrst_data_out",   data_out,   1'b1);
    check("midrst_bit_index",  bit_index,  4'd0);
    check("midrst_frame_done", frame_done, 1'b0);
    check("midrst_host_idle",  host_idle,  1'b1);
    pulse_in = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(5);

    // Randomized host traffic; one pin changes per step, held >= SYNC+2.
    for (int s = 0; s < 160; s++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3)      latch_in = ~latch_in;
      else if (r < 9) pulse_in = ~pulse_in;
      if ($urandom_range(0, 1) == 1) buttons_in = 8'($urandom);
      tick(int'($urandom_range(SYNC + 2, 16)));
    end
    latch_in = 1'b0;
    pulse_in = 1'b0;
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nes_pad_emulator.md
Name: nes_pad_emulator

Overview:
- Device side of the NES controller serial protocol: behaves like the pad's 4021 parallel-in/serial-out shift register on the wire.
- Responds to latch/pulse from an NES host (our own NES reader, or an external console/adapter) and serially returns an 8-button snapshot on data.
- Lets bongo or switch inputs stand in for a physical NES pad in closed-loop tests and in builds without a pad.

Parameters:
- SYNC_STAGES, 2, synchronizer depth applied to latch_in and pulse_in (minimum 2).
- IDLE_TIMEOUT, 1_000_000, clk cycles without a latch rising edge before host_idle asserts.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- buttons_in  input  [0:7]  active-high button states, order A,B,Select,Start,Up,Down,Left,Right.
- latch_in  input  1  host latch, asynchronous to clk.
- pulse_in  input  1  host clock pulse, asynchronous to clk.
- data_out  output  1  serial data, wire-level active-low (0 = pressed), registered.
- frame_done  output  1  one-cycle strobe when the last button bit (Right) is presented.
- bit_index  output  [3:0]  index of the bit currently on data_out (0..7); 8 = exhausted.
- host_idle  output  1  high while no latch has been seen for IDLE_TIMEOUT cycles.

Behaviour:
- Synchronization: latch_in and pulse_in each pass through SYNC_STAGES flops, then a rising-edge detector. All logic below uses the synchronized signals.
- Shift register: sreg[0:7] holds wire-level bits (sreg = ~buttons_in at load). data_out is registered from sreg[0].
- States: IDLE, LOAD, SHIFT, DONE.
- Reset (async, any time, including mid-frame):
  - state=IDLE, sreg=8'hFF, data_out=1, bit_index=0, frame_done=0.
  - host_idle=1, idle counter=0, synchronizer flops=0.
- IDLE or any state, synced latch high:
  - Go to LOAD.
  - Continuously reload sreg from ~buttons_in every cycle (parallel mode dominates); bit_index=0.
  - Pulse edges are ignored while latch is high.
- LOAD, synced latch falls: go to SHIFT holding the last loaded value; data_out presents A.
- SHIFT, pulse rising edge:
  - sreg shifts toward index 0, with 0 entering at index 7.
  - bit_index increments.
  - When bit_index goes 6->7: assert frame_done for exactly one cycle and go to DONE.
- DONE, further pulse rising edge:
  - Shift continues, so data_out becomes 0 (matches the original pad's grounded serial input).
  - bit_index goes 7->8 and saturates at 8; no additional frame_done.
- Latch rising edge mid-SHIFT: abort the frame, go to LOAD, bit_index=0, no frame_done.
- Latency: data_out reflects a pin edge within SYNC_STAGES+2 clk cycles. The host must hold each latch/pulse level at least SYNC_STAGES+2 cycles; shorter glitches may be missed and are unspecified.
- host_idle / idle counter:
  - Counter increments each cycle and saturates at IDLE_TIMEOUT.
  - A synced latch rising edge clears the counter and host_idle in the same cycle.
  - host_idle=1 when counter==IDLE_TIMEOUT.
  - host_idle does not change state or data.
- Simultaneous latch and pulse edges in the same cycle: latch wins, pulse is ignored.
- Counter width: ceil(log2(IDLE_TIMEOUT+1)).

Decomposition:
- Shared package nes_pkg:
  - localparams BTN_A=0, BTN_B=1, BTN_SELECT=2, BTN_START=3, BTN_UP=4, BTN_DOWN=5, BTN_LEFT=6, BTN_RIGHT=7; NES_BITS=8.
  - Typedef nes_pad_state_t {IDLE, LOAD, SHIFT, DONE}.
  - The NES reader uses the same button indices.
- One sub-module, sync_edge: parameterized synchronizer plus rising-edge detector with async active-high reset. Instantiated twice (latch, pulse).

Test Plan:
- Reset released, no activity -> data_out=1, bit_index=0, host_idle=1, frame_done=0.
- buttons_in=8'b0001_0000 (Start, index 3); latch 12 cycles then low; 7 pulses of 12 cycles high/low:
  - data_out sequence 1,1,1,0,1,1,1,1 read after each edge.
  - frame_done pulses once after the 7th pulse; bit_index=7.
- Continue with 2 extra pulses after the frame -> data_out=0, bit_index saturates at 8, no second frame_done.
- Latch asserted after 3 pulses with buttons_in changed to 8'b1000_0000 -> bit_index returns to 0, data_out=0 (A pressed), no frame_done for the aborted frame.
- buttons_in toggles while latch is high; latch falls -> the value sampled in the final latch-high cycles is what shifts out. Pulses during latch high cause no shift.
- IDLE_TIMEOUT=100: latch once, then wait 100 cycles -> host_idle rises at cycle 100 after the synced edge. Next latch clears it within SYNC_STAGES+2 cycles. Assert rst mid-SHIFT -> all outputs return to reset values immediately.
